jtdd_objdma: RTL and testbench

//  Object-RAM DMA controller for the sprite path. On each vertical blank it copies the
//  CPU-shared object RAM into the private object buffer scanned by the sprite engine.
//  The scanner then never contends with the CPU during active video.
//  It sits between the CPU bus / shared RAM mux and the object buffer read by the scanner.

---
 rtl/jtdd_objdma.sv | 167 ++++++++++++++++
 tb/tb_jtdd_objdma.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_objdma.sv
// jtdd_objdma: copies the CPU-shared object RAM into the sprite object buffer during vertical blank.
// Optional macro JTDD_OBJDMA_BUSREQ_EN halts the CPU via busreq/busak instead of stealing idle cycles.
module jtdd_objdma #(
    parameter int AW  = 9,
    parameter int LEN = 510
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          VBL,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_we,
    input  logic          cpu_cs,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_din,
    output logic          buf_we,
    output logic          busreq,
    input  logic          busak,
    output logic          busy,
    output logic          done,
    output logic          overrun
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COPY,
        LAST,
        DONE
    } state_t;

    state_t        state;
    logic          vbl_q;
    logic [AW-1:0] cnt;
    logic [AW-1:0] rd_ptr;
    logic          rd_vld;
    logic          issued_q;
    logic [7:0]    rd_hold;
    logic          vbl_rise;
    logic          grant;
    logic          dma_read;

`ifdef JTDD_OBJDMA_BUSREQ_EN
    logic          busreq_r;

    assign grant  = 1'b1;
    assign busreq = busreq_r;
`else
    logic          unused_busak;

    assign unused_busak = busak;
    assign grant        = ~cpu_cs;
    assign busreq       = 1'b0;
`endif

    assign vbl_rise = VBL & ~vbl_q;
    assign dma_read = (state == COPY) & grant & VBL;

    // The CPU keeps the shared port whenever the DMA is not actually reading
    assign ram_addr = dma_read ? cnt : cpu_addr;
    assign ram_din  = cpu_dout;
    assign ram_we   = cpu_cs & cpu_we;

    assign buf_we   = cen & rd_vld;
    assign buf_addr = rd_ptr;
    assign buf_din  = issued_q ? ram_dout : rd_hold;

    // RAM data is only valid on the clock right after the read, so hold it across cen gaps
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            issued_q <= 1'b0;
            rd_hold  <= 8'd0;
        end else begin
            issued_q <= cen & dma_read;
            if (issued_q) rd_hold <= ram_dout;
        end
    end

    // vbl_q resets high so a blank already in progress at reset release does not start a copy
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vbl_q    <= 1'b1;
            cnt      <= '0;
            rd_ptr   <= '0;
            rd_vld   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
`ifdef JTDD_OBJDMA_BUSREQ_EN
            busreq_r <= 1'b0;
`endif
        end else if (cen) begin
            vbl_q  <= VBL;
            rd_vld <= 1'b0;
            done   <= 1'b0;
            if (vbl_rise) begin
                overrun <= 1'b0;
                cnt     <= '0;
                busy    <= 1'b1;
`ifdef JTDD_OBJDMA_BUSREQ_EN
                busreq_r <= 1'b1;
                state    <= REQ;
`else
                state    <= COPY;
`endif
            end else begin
                case (state)
                    REQ: begin
                        if (!VBL) begin
                            state   <= IDLE;
                            overrun <= 1'b1;
                            busy    <= 1'b0;
`ifdef JTDD_OBJDMA_BUSREQ_EN
                            busreq_r <= 1'b0;
`endif
                        end else if (busak) begin
                            state <= COPY;
                        end
                    end
                    COPY: begin
                        if (!VBL) begin
                            state   <= IDLE;
                            overrun <= 1'b1;
                            busy    <= 1'b0;
`ifdef JTDD_OBJDMA_BUSREQ_EN
                            busreq_r <= 1'b0;
`endif
                        end else if (grant) begin
                            rd_vld <= 1'b1;
                            rd_ptr <= cnt;
                            cnt    <= cnt + 1'b1;
                            if (cnt == LAST_ADDR) state <= LAST;
                        end
                    end
                    // The final read's write-back happens on this cen through rd_vld
                    LAST: begin
                        if (!VBL) begin
                            state   <= IDLE;
                            overrun <= 1'b1;
                            busy    <= 1'b0;
`ifdef JTDD_OBJDMA_BUSREQ_EN
                            busreq_r <= 1'b0;
`endif
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef JTDD_OBJDMA_BUSREQ_EN
                            busreq_r <= 1'b0;
`endif
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtdd_objdma.sv
// tb_jtdd_objdma: randomized directed bench for the object RAM DMA, with a byte-level copy model.
// Honours JTDD_OBJDMA_BUSREQ_EN when the design is built with it.
module tb_jtdd_objdma;
    localparam int AW  = 9;
    localparam int LEN = 510;
`ifdef JTDD_OBJDMA_BUSREQ_EN
    localparam int BR = 1;
`else
    localparam int BR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cen;
    logic          VBL;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic          cpu_we;
    logic          cpu_cs;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_din;
    logic          buf_we;
    logic          busreq;
    logic          busak;
    logic          busy;
    logic          done;
    logic          overrun;

    logic [7:0] sram      [0:511];
    logic [7:0] obuf      [0:511];
    logic [7:0] model_ram [0:511];
    logic [7:0] exp_buf   [0:511];

    int we_count   = 0;
    int done_count = 0;
    int errors     = 0;
    int checks     = 0;

    int r_done_tick, r_ak_tick, r_first_we;
    logic r_busreq_at_done;

    jtdd_objdma #(.AW(AW), .LEN(LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .VBL      (VBL),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .cpu_cs   (cpu_cs),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .buf_addr (buf_addr),
        .buf_din  (buf_din),
        .buf_we   (buf_we),
        .busreq   (busreq),
        .busak    (busak),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Shared RAM with one clock of read latency, plus the object buffer and pulse counters
    always @(posedge clk) begin
        if (ram_we) sram[ram_addr] <= ram_din;
        ram_dout <= sram[ram_addr];
        if (buf_we) begin
            obuf[buf_addr] <= buf_din;
            we_count       <= we_count + 1;
        end
        if (cen && done) done_count <= done_count + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_ram(input bit pattern);
        for (int i = 0; i < 512; i++) begin
            cpu_cs   = 1'b1;
            cpu_we   = 1'b1;
            cpu_addr = AW'(i);
            cpu_dout = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
            model_ram[i] = cpu_dout;
            tick();
        end
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
    endtask

    // mode: 0 quiet CPU, 1 CPU every 2nd cen, 2 random CPU, 3 scripted writes to 509 and 0
    task automatic apply_stimulus(input int mode, input int abort_at, input int rst_at,
                                  input int ak_delay, input bit gaps);
        int k, c, last_read, addr_err, mism, we0, done0;
        bit copy_on;
        k = 0; c = 0; last_read = -1; addr_err = 0; mism = 0;
        copy_on = (BR == 0);
        r_done_tick = -1; r_ak_tick = -1; r_first_we = -1; r_busreq_at_done = 1'bx;
        cpu_cs = 1'b0; cpu_we = 1'b0; busak = 1'b0; cen = 1'b1;
        VBL = 1'b0;
        tick(); tick();
        we0 = we_count; done0 = done_count;
        VBL = 1'b1;
        tick();
        check_output("busy_after_rise", busy, 1);
        check_output("overrun_clear_on_rise", overrun, 0);
        check_output("busreq_after_rise", busreq, BR);
        while (c < 2500) begin
            if (gaps) begin
                cpu_cs = 1'b0; cpu_we = 1'b0; cen = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                cen = 1'b1;
            end
            c++;
            cpu_cs = 1'b0; cpu_we = 1'b0;
            busak = (BR != 0) && (c > ak_delay);
            if (c == abort_at) VBL = 1'b0;
            if (c == rst_at) begin
                check_output("pre_rst_buf_we", buf_we, 1);
                rst = 1'b1;
                #1;
                check_output("rst_busy", busy, 0);
                check_output("rst_buf_we", buf_we, 0);
                break;
            end
            if (BR == 0 && VBL && k < LEN) begin
                case (mode)
                    1:       cpu_cs = (c % 2 == 0);
                    2:       cpu_cs = ($urandom_range(0, 2) == 0);
                    3:       cpu_cs = (c == 5 || c == 300);
                    default: cpu_cs = 1'b0;
                endcase
                if (cpu_cs) begin
                    cpu_we   = (mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
                    cpu_addr = (mode == 3) ? ((c == 5) ? AW'(509) : AW'(0)) : AW'($urandom_range(0, 511));
                    cpu_dout = (mode == 3) ? 8'hFF : 8'($urandom);
                end
            end
            #1;
            if (cpu_cs && ram_addr !== cpu_addr) addr_err++;
            if (copy_on && VBL && k < LEN && !cpu_cs && ram_addr !== AW'(k)) addr_err++;
            // Each granted cen reads the next address; a CPU write lands before any later read
            if (copy_on && VBL && k < LEN && (BR != 0 || !cpu_cs)) begin
                exp_buf[k] = model_ram[k];
                k++;
                if (k == LEN) last_read = c;
            end
            if (cpu_cs && cpu_we) model_ram[cpu_addr] = cpu_dout;
            if (BR != 0 && !copy_on && busak && VBL) begin
                copy_on   = 1'b1;
                r_ak_tick = c;
            end
            tick();
            if (r_first_we < 0 && we_count != we0) r_first_we = c;
            if (done && r_done_tick < 0) begin
                r_done_tick      = c;
                r_busreq_at_done = busreq;
                check_output("busy_low_at_done", busy, 0);
            end
            if (r_done_tick >= 0) break;
            if (abort_at > 0 && c >= abort_at + 4) break;
        end
        cpu_cs = 1'b0; cpu_we = 1'b0;
        tick();
        for (int i = 0; i < k; i++) if (obuf[i] !== exp_buf[i]) mism++;
        check_output("buf_data_mismatches", mism, 0);
        check_output("ram_addr_mux_errors", addr_err, 0);
        if (rst_at > 0) begin
            tick();
            rst = 1'b0;
            we0 = we_count;
            repeat (5) tick();
            check_output("post_rst_idle_busy", busy, 0);
            check_output("post_rst_no_writes", we_count - we0, 0);
            check_output("post_rst_no_done", done_count - done0, 0);
        end else if (abort_at > 0) begin
            check_output("abort_overrun", overrun, 1);
            check_output("abort_busy", busy, 0);
            check_output("abort_buf_we_low", buf_we, 0);
            check_output("abort_write_count", we_count - we0, k);
            check_output("abort_no_done", done_count - done0, 0);
        end else begin
            check_output("done_latency", r_done_tick, last_read + 1);
            check_output("write_count", we_count - we0, LEN);
            check_output("done_pulses", done_count - done0, 1);
            check_output("overrun_after_copy", overrun, 0);
            check_output("busreq_at_done", r_busreq_at_done, 0);
        end
        VBL = 1'b0; busak = 1'b0;
        tick(); tick();
    endtask

    initial begin
        logic [7:0] old0;
        rst = 1'b1; cen = 1'b1; VBL = 1'b0;
        cpu_addr = 9'h1A3; cpu_dout = 8'h00; cpu_we = 1'b0; cpu_cs = 1'b0; busak = 1'b0;
        #1;
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_overrun", overrun, 0);
        check_output("reset_buf_we", buf_we, 0);
        check_output("reset_busreq", busreq, 0);
        check_output("reset_buf_addr", buf_addr, 0);
        check_output("reset_ram_addr", ram_addr, 9'h1A3);
        tick(); tick();
        rst = 1'b0;
        tick();

        $display("[TB] plain copy of i^5A");
        fill_ram(1'b1);
        apply_stimulus(0, -1, -1, 0, 1'b0);
        check_output("plain_done_latency", r_done_tick, LEN + 1 + BR);
        check_output("plain_first_write", r_first_we, 2 + BR);

        $display("[TB] CPU on every second cen");
        fill_ram(1'b0);
        apply_stimulus(1, -1, -1, 0, 1'b0);
`ifndef JTDD_OBJDMA_BUSREQ_EN
        check_output("steal_copy_length", r_done_tick, 2 * LEN);
`endif

        $display("[TB] scripted CPU writes during copy");
        fill_ram(1'b0);
        old0 = model_ram[0];
        apply_stimulus(3, -1, -1, 0, 1'b0);
`ifndef JTDD_OBJDMA_BUSREQ_EN
        check_output("buf0_keeps_old", obuf[0], old0);
        check_output("buf509_sees_cpu", obuf[509], 8'hFF);
        check_output("ram0_written", sram[0], 8'hFF);
`endif

        $display("[TB] random CPU traffic with cen gaps");
        apply_stimulus(2, -1, -1, 0, 1'b1);

        $display("[TB] VBL falls mid-copy");
        apply_stimulus(0, 100, -1, 0, 1'b0);
        apply_stimulus(2, -1, -1, 0, 1'b0);

        $display("[TB] reset mid-copy");
        apply_stimulus(0, -1, 50, 0, 1'b0);
        apply_stimulus(0, -1, -1, 0, 1'b0);

`ifdef JTDD_OBJDMA_BUSREQ_EN
        $display("[TB] delayed bus acknowledge");
        apply_stimulus(0, -1, -1, 10, 1'b0);
        check_output("no_write_before_busak", r_first_we > r_ak_tick, 1);
        check_output("copy_span_after_busak", r_done_tick - r_ak_tick, LEN + 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
